prog_mem_ctrl: RTL and testbench
================================

Name: prog_mem_ctrl

Overview:
Parametrised program memory for the TTM4 emulator and its wider successors. Holds the instruction store as BANKS byte-wide lanes in one inferred synchronous RAM. It adds an in-system byte-stream loader (valid/ready handshake) and a registered fetch port with a valid strobe. It sits between the host/UART loader and the CPU core; field decode of INSTR (IM/LR/SR/OP) stays in the core.

Parameters:
ADDR_W, 8, instruction address width; DEPTH = 2**ADDR_W words
BYTE_W, 8, width of one bank lane and of the load stream
BANKS, 2, bytes per instruction word; INSTR width = BANKS*BYTE_W

Ports:
CLK  in  1  system clock, all logic on rising edge
nRST  in  1  asynchronous active-low reset
LOAD_EN  in  1  level; high requests load mode
LD_DATA  in  BYTE_W  load byte, bank 0 (LSB lane) first
LD_VALID  in  1  LD_DATA valid
LD_READY  out  1  block accepts byte this cycle
LD_LAST  in  1  qualifies final byte of program
LD_DONE  out  1  one-cycle pulse: load finished
LD_ADDR  out  ADDR_W  word address currently being filled
FETCH  in  1  fetch request, sampled with ADD
ADD  in  ADDR_W  fetch word address
INSTR  out  BANKS*BYTE_W  fetched instruction word
INSTR_VALID  out  1  one-cycle pulse, INSTR updated
BUSY  out  1  high in any state except S_RUN

Behaviour:
- Reset (nRST low, async): state S_RUN; LD_READY=0, LD_DONE=0, LD_ADDR=0, byte index=0, INSTR=0, INSTR_VALID=0, BUSY=0. RAM contents are not reset and are retained across reset.
- States:
  - S_RUN: serves fetches. LOAD_EN=1 -> S_LOAD, LD_ADDR:=0, byte index:=0.
  - S_LOAD: LD_READY=1. On LD_VALID&LD_READY, the byte goes into lane[index] of the assembly register and index increments.
    - Byte at index BANKS-1 -> S_WRITE.
    - LD_LAST on an earlier byte -> remaining lanes zero-filled, -> S_WRITE with the last flag set.
    - LOAD_EN=0 -> partial word discarded, no write, no LD_DONE, -> S_RUN.
  - S_WRITE: one cycle; LD_READY=0; the assembled word is written at LD_ADDR.
    - If the last flag is set or LD_ADDR==DEPTH-1: LD_DONE pulses this cycle, -> S_DONE.
    - Otherwise LD_ADDR++, index:=0, assembly register cleared, -> S_LOAD.
  - S_DONE: LD_READY=0; waits for LOAD_EN=0 -> S_RUN. Bytes offered here are ignored.
- Load throughput: BANKS bytes per BANKS+1 cycles.
- Fetch: only in S_RUN. FETCH high at edge N -> INSTR = mem[ADD] and INSTR_VALID=1 after edge N+1 (1-cycle latency). Back-to-back fetches give one result per cycle. INSTR holds its last value when no fetch is in progress. INSTR_VALID is 0 otherwise.
- Simultaneous events:
  - FETCH and LOAD_EN both high in S_RUN: load wins; the fetch is dropped (no INSTR_VALID).
  - A fetch issued the cycle before entering S_LOAD still completes with its INSTR_VALID.
  - FETCH in any non-RUN state is ignored.
- Read-during-write does not occur, because fetch and write are mutually exclusive by state.
- Reset mid-load: the partially written program remains in RAM; LD_ADDR and index return to 0.
- Widths: LD_ADDR wraps are never taken. The load terminates at DEPTH-1 instead of wrapping to 0.

Test Plan:
1. Reset values: assert nRST=0 mid-operation -> all outputs 0 and state S_RUN; a fetch of a preloaded address after reset returns the old contents.
2. Load then fetch (defaults): LOAD_EN=1; stream 34,12,78,56,BC,9A (hex) with LD_LAST on 9A -> LD_DONE pulses once and LD_ADDR=2. Then LOAD_EN=0; fetch 0,1,2 back-to-back -> INSTR 1234, 5678, 9ABC (hex) on three consecutive cycles, each with INSTR_VALID.
3. Partial word: BANKS=3; stream AA,BB then LD_LAST on BB -> word 00BBAA (hex) written, LD_DONE=1, LD_READY low during S_WRITE.
4. Abort: stream one byte 55 (hex) for word 4, then drop LOAD_EN -> word 4 unchanged, no LD_DONE, BUSY=0 the next cycle.
5. Full depth: ADDR_W=3; stream 16 bytes with no LD_LAST -> LD_DONE on the write of address 7. A 17th byte is not accepted (LD_READY=0) and word 0 is not overwritten.
6. Priority: FETCH=1 and LOAD_EN=1 in the same cycle -> no INSTR_VALID, BUSY=1 next cycle. A fetch issued the prior cycle still returns with INSTR_VALID.

Source files
------------

// File: rtl/prog_mem_ctrl.sv
// rtl/prog_mem_ctrl.sv - banked program memory with byte-stream loader and registered fetch port
module prog_mem_ctrl #(
    parameter int ADDR_W = 8,
    parameter int BYTE_W = 8,
    parameter int BANKS  = 2
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic                      LOAD_EN,
    input  logic [BYTE_W-1:0]         LD_DATA,
    input  logic                      LD_VALID,
    output logic                      LD_READY,
    input  logic                      LD_LAST,
    output logic                      LD_DONE,
    output logic [ADDR_W-1:0]         LD_ADDR,
    input  logic                      FETCH,
    input  logic [ADDR_W-1:0]         ADD,
    output logic [BANKS*BYTE_W-1:0]   INSTR,
    output logic                      INSTR_VALID,
    output logic                      BUSY
);

    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int WORD_W = BANKS * BYTE_W;
    localparam int IDX_W  = (BANKS > 1) ? $clog2(BANKS) : 1;

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(BANKS - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    typedef enum logic [1:0] {
        S_RUN,
        S_LOAD,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [WORD_W-1:0]   asm_word;
    logic                last_flag;
    logic [ADDR_W-1:0]   ld_addr_q;
    logic                fetch_q;
    logic [WORD_W-1:0]   rd_data;
    logic [WORD_W-1:0]   instr_q;
    logic                instr_valid_q;
    logic                fetch_go;

    logic [WORD_W-1:0]   mem [DEPTH];

    // Load mode takes priority over a fetch presented in the same cycle.
    assign fetch_go = (state == S_RUN) && FETCH && !LOAD_EN;

    // RAM kept free of reset so it infers as a plain synchronous block RAM.
    always_ff @(posedge CLK) begin
        if (state == S_WRITE) begin
            mem[ld_addr_q] <= asm_word;
        end
        if (fetch_go) begin
            rd_data <= mem[ADD];
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state         <= S_RUN;
            idx           <= '0;
            asm_word      <= '0;
            last_flag     <= 1'b0;
            ld_addr_q     <= '0;
            fetch_q       <= 1'b0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            // Fetch pipeline runs independently of the load FSM once issued.
            fetch_q       <= fetch_go;
            instr_valid_q <= fetch_q;
            if (fetch_q) begin
                instr_q <= rd_data;
            end

            case (state)
                S_RUN: begin
                    if (LOAD_EN) begin
                        state     <= S_LOAD;
                        ld_addr_q <= '0;
                        idx       <= '0;
                        asm_word  <= '0;
                        last_flag <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (!LOAD_EN) begin
                        state <= S_RUN;
                        idx   <= '0;
                    end else if (LD_VALID) begin
                        for (int b = 0; b < BANKS; b++) begin
                            if (idx == IDX_W'(b)) begin
                                asm_word[b*BYTE_W +: BYTE_W] <= LD_DATA;
                            end
                        end
                        idx <= idx + IDX_ONE;
                        if ((idx == IDX_LAST) || LD_LAST) begin
                            state     <= S_WRITE;
                            last_flag <= LD_LAST;
                        end
                    end
                end
                S_WRITE: begin
                    if (last_flag || (ld_addr_q == ADDR_LAST)) begin
                        state <= S_DONE;
                    end else begin
                        state     <= S_LOAD;
                        ld_addr_q <= ld_addr_q + ADDR_ONE;
                        idx       <= '0;
                        asm_word  <= '0;
                    end
                end
                S_DONE: begin
                    if (!LOAD_EN) begin
                        state <= S_RUN;
                    end
                end
                default: state <= S_RUN;
            endcase
        end
    end

    assign LD_READY    = (state == S_LOAD);
    assign LD_DONE     = (state == S_WRITE) && (last_flag || (ld_addr_q == ADDR_LAST));
    assign LD_ADDR     = ld_addr_q;
    assign BUSY        = (state != S_RUN);
    assign INSTR       = instr_q;
    assign INSTR_VALID = instr_valid_q;

endmodule

// File: tb/tb_prog_mem_ctrl.sv
// tb/tb_prog_mem_ctrl.sv - scoreboard bench for prog_mem_ctrl
module tb_prog_mem_ctrl;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [7:0]  ld_data;
    logic        ld_valid;
    logic        ld_last;
    logic [7:0]  add;

    logic        load_en_m, fetch_m, ld_ready_m, ld_done_m, instr_valid_m, busy_m;
    logic [7:0]  ld_addr_m;
    logic [15:0] instr_m;

    logic        load_en_p, fetch_p, ld_ready_p, ld_done_p, instr_valid_p, busy_p;
    logic [7:0]  ld_addr_p;
    logic [23:0] instr_p;

    logic        load_en_d, fetch_d, ld_ready_d, ld_done_d, instr_valid_d, busy_d;
    logic [2:0]  ld_addr_d;
    logic [15:0] instr_d;

    int n_checks = 0;
    int n_fail   = 0;
    int done_m = 0, done_p = 0, done_d = 0;

    logic [23:0] q_m[$];
    logic [23:0] q_p[$];
    logic [23:0] q_d[$];

    always #5 CLK = ~CLK;

    prog_mem_ctrl u_main (
        .CLK(CLK), .nRST(nRST), .LOAD_EN(load_en_m), .LD_DATA(ld_data), .LD_VALID(ld_valid),
        .LD_READY(ld_ready_m), .LD_LAST(ld_last), .LD_DONE(ld_done_m), .LD_ADDR(ld_addr_m),
        .FETCH(fetch_m), .ADD(add), .INSTR(instr_m), .INSTR_VALID(instr_valid_m), .BUSY(busy_m)
    );

    prog_mem_ctrl #(.BANKS(3)) u_b3 (
        .CLK(CLK), .nRST(nRST), .LOAD_EN(load_en_p), .LD_DATA(ld_data), .LD_VALID(ld_valid),
        .LD_READY(ld_ready_p), .LD_LAST(ld_last), .LD_DONE(ld_done_p), .LD_ADDR(ld_addr_p),
        .FETCH(fetch_p), .ADD(add), .INSTR(instr_p), .INSTR_VALID(instr_valid_p), .BUSY(busy_p)
    );

    prog_mem_ctrl #(.ADDR_W(3)) u_d8 (
        .CLK(CLK), .nRST(nRST), .LOAD_EN(load_en_d), .LD_DATA(ld_data), .LD_VALID(ld_valid),
        .LD_READY(ld_ready_d), .LD_LAST(ld_last), .LD_DONE(ld_done_d), .LD_ADDR(ld_addr_d),
        .FETCH(fetch_d), .ADD(add[2:0]), .INSTR(instr_d), .INSTR_VALID(instr_valid_d), .BUSY(busy_d)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Output monitors: pop the expected word whenever a DUT strobes INSTR_VALID.
    always @(negedge CLK) begin
        logic [23:0] e;
        if (ld_done_m) done_m++;
        if (ld_done_p) done_p++;
        if (ld_done_d) done_d++;
        if (instr_valid_m) begin
            if (q_m.size() == 0) check("main_unexpected_valid", 32'(instr_m), 32'hFFFF_FFFF);
            else begin e = q_m.pop_front(); check("main_instr", 32'(instr_m), 32'(e[15:0])); end
        end
        if (instr_valid_p) begin
            if (q_p.size() == 0) check("b3_unexpected_valid", 32'(instr_p), 32'hFFFF_FFFF);
            else begin e = q_p.pop_front(); check("b3_instr", 32'(instr_p), 32'(e)); end
        end
        if (instr_valid_d) begin
            if (q_d.size() == 0) check("d8_unexpected_valid", 32'(instr_d), 32'hFFFF_FFFF);
            else begin e = q_d.pop_front(); check("d8_instr", 32'(instr_d), 32'(e[15:0])); end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic rdy(input int sel);
        case (sel)
            0:       return ld_ready_m;
            1:       return ld_ready_p;
            default: return ld_ready_d;
        endcase
    endfunction

    task automatic send(input int sel, input logic [7:0] d, input logic last);
        int n = 0;
        ld_data  = d;
        ld_valid = 1'b1;
        ld_last  = last;
        while (!rdy(sel) && n < 20) begin
            tick();
            n++;
        end
        if (!rdy(sel)) check("send_ready_timeout", 32'(n), 32'd0);
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic fetch_one(input int sel, input logic [7:0] a, input logic [23:0] exp);
        add = a;
        case (sel)
            0:       begin fetch_m = 1'b1; q_m.push_back(exp); end
            1:       begin fetch_p = 1'b1; q_p.push_back(exp); end
            default: begin fetch_d = 1'b1; q_d.push_back(exp); end
        endcase
        tick();
    endtask

    task automatic fetch_stop();
        fetch_m = 1'b0;
        fetch_p = 1'b0;
        fetch_d = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] prog2 [6];
        logic [7:0] prog4 [10];
        int d0;
        prog2 = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};
        prog4 = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'hDE, 8'h44, 8'h44};
        nRST = 1'b0; ld_data = '0; ld_valid = 1'b0; ld_last = 1'b0; add = '0;
        load_en_m = 0; fetch_m = 0; load_en_p = 0; fetch_p = 0; load_en_d = 0; fetch_d = 0;
        repeat (3) tick();
        check("rst_ld_ready", 32'(ld_ready_m), 32'd0);
        check("rst_instr", 32'(instr_m), 32'd0);
        check("rst_busy", 32'(busy_m), 32'd0);
        nRST = 1'b1;
        tick();

        // Load three words and fetch them back-to-back.
        load_en_m = 1'b1;
        tick();
        check("t2_busy_load", 32'(busy_m), 32'd1);
        for (int i = 0; i < 6; i++) send(0, prog2[i], i == 5);
        repeat (2) tick();
        check("t2_done_count", 32'(done_m), 32'd1);
        check("t2_ld_addr", 32'(ld_addr_m), 32'd2);
        check("t2_ready_in_done", 32'(ld_ready_m), 32'd0);
        load_en_m = 1'b0;
        tick();
        check("t2_busy_run", 32'(busy_m), 32'd0);
        fetch_one(0, 8'd0, 24'h1234);
        fetch_one(0, 8'd1, 24'h5678);
        fetch_one(0, 8'd2, 24'h9ABC);
        fetch_stop();

        // Asynchronous reset in the middle of a load.
        load_en_m = 1'b1;
        tick();
        send(0, 8'h77, 1'b0);
        nRST = 1'b0;
        #2;
        check("t1_ld_ready", 32'(ld_ready_m), 32'd0);
        check("t1_ld_done", 32'(ld_done_m), 32'd0);
        check("t1_ld_addr", 32'(ld_addr_m), 32'd0);
        check("t1_instr", 32'(instr_m), 32'd0);
        check("t1_instr_valid", 32'(instr_valid_m), 32'd0);
        check("t1_busy", 32'(busy_m), 32'd0);
        load_en_m = 1'b0;
        tick();
        nRST = 1'b1;
        tick();
        fetch_one(0, 8'd1, 24'h5678);
        fetch_stop();

        // Preload word 4, then abort a reload partway into word 4.
        load_en_m = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) send(0, prog4[i], i == 9);
        repeat (2) tick();
        load_en_m = 1'b0;
        tick();
        d0 = done_m;
        load_en_m = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) send(0, prog4[i], 1'b0);
        send(0, 8'h55, 1'b0);
        check("t4_ld_addr", 32'(ld_addr_m), 32'd4);
        load_en_m = 1'b0;
        tick();
        check("t4_busy_after_abort", 32'(busy_m), 32'd0);
        check("t4_no_done", 32'(done_m), 32'(d0));
        fetch_one(0, 8'd4, 24'h4444);
        fetch_one(0, 8'd3, 24'hDEF0);
        fetch_stop();

        // Fetch and LOAD_EN together: fetch dropped; prior-cycle fetch completes.
        fetch_m = 1'b1; add = 8'd1; load_en_m = 1'b1;
        tick();
        check("t6_busy", 32'(busy_m), 32'd1);
        fetch_m = 1'b0; load_en_m = 1'b0;
        repeat (2) tick();
        fetch_one(0, 8'd2, 24'h9ABC);
        fetch_m = 1'b0; load_en_m = 1'b1;
        tick();
        check("t6_busy_prior", 32'(busy_m), 32'd1);
        load_en_m = 1'b0;
        repeat (3) tick();

        // Three-lane word terminated early by LD_LAST.
        load_en_p = 1'b1;
        tick();
        send(1, 8'hAA, 1'b0);
        send(1, 8'hBB, 1'b1);
        check("t3_ready_in_write", 32'(ld_ready_p), 32'd0);
        check("t3_ld_done", 32'(ld_done_p), 32'd1);
        tick();
        load_en_p = 1'b0;
        repeat (2) tick();
        check("t3_done_count", 32'(done_p), 32'd1);
        fetch_one(1, 8'd0, 24'h00BBAA);
        fetch_stop();

        // Fill all 8 words; load stops at the top address.
        load_en_d = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) send(2, 8'(i + 1), 1'b0);
        check("t5_done_at_top", 32'(ld_done_d), 32'd1);
        check("t5_ld_addr", 32'(ld_addr_d), 32'd7);
        tick();
        ld_data = 8'hEE; ld_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("t5_ready_17th", 32'(ld_ready_d), 32'd0);
            tick();
        end
        ld_valid = 1'b0;
        check("t5_done_count", 32'(done_d), 32'd1);
        load_en_d = 1'b0;
        repeat (2) tick();
        fetch_one(2, 8'd0, 24'h0201);
        fetch_one(2, 8'd7, 24'h100F);
        fetch_stop();

        check("q_main_empty", 32'(q_m.size()), 32'd0);
        check("q_b3_empty", 32'(q_p.size()), 32'd0);
        check("q_d8_empty", 32'(q_d.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
